// File: rtl/pulse_stretch.sv
// Retriggerable-optional pulse stretcher: a trigger starts a registered pulse of len cycles.
// Optional build macro PULSE_STRETCH_RETRIG_EN lets a trigger while active reload the length.
module pulse_stretch #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trig,
   input  logic [WIDTH-1:0] len,
   output logic             out,
   output logic             done,
   output logic             ovr
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             ovr_q, ovr_d;
   logic             len_ok;

   assign len_ok = (len != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      ovr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (trig && len_ok) begin
               state_d = ACTIVE;
               cnt_d   = len;
            end
         end
         ACTIVE: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
`ifdef PULSE_STRETCH_RETRIG_EN
            // A reload overrides the expiry decided above, so the pulse never gaps.
            if (trig && len_ok) begin
               state_d = ACTIVE;
               cnt_d   = len;
               done_d  = 1'b0;
            end else begin
               ovr_d = trig;
            end
`else
            ovr_d = trig;
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign out  = (state_q == ACTIVE);
   assign done = done_q;
   assign ovr  = ovr_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench for pulse_stretch: directed scenarios then random traffic
// compared against a deadline-based model of the pulse.
module tb_pulse_stretch;

   logic       clk;
   logic       rst;
   logic       trig;
   logic [7:0] len;
   logic       out;
   logic       done;
   logic       ovr;

   int n_assert;
   int n_fail;

   // Model: fall_edge is the edge index on which the current pulse ends.
   int   n_edge;
   int   fall_edge;
   logic e_out, e_done, e_ovr;

   pulse_stretch #(.WIDTH(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .trig (trig),
      .len  (len),
      .out  (out),
      .done (done),
      .ovr  (ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s @edge %0d: observed %b expected %b", tag, n_edge, obs, exp);
      end
   endtask

   task automatic model_reset();
      fall_edge = -1;
      e_out  = 1'b0;
      e_done = 1'b0;
      e_ovr  = 1'b0;
   endtask

   task automatic model_edge(input logic t, input logic [7:0] l);
      bit active;
      active = (n_edge <= fall_edge);
      e_done = 1'b0;
      e_ovr  = 1'b0;
      if (!active) begin
         if (t && l != 0) fall_edge = n_edge + int'(l);
      end else begin
`ifdef PULSE_STRETCH_RETRIG_EN
         if (t && l != 0) fall_edge = n_edge + int'(l);
         else if (t) e_ovr = 1'b1;
`else
         if (t) e_ovr = 1'b1;
`endif
         if (n_edge == fall_edge) e_done = 1'b1;
      end
      e_out = (n_edge < fall_edge);
      n_edge++;
   endtask

   task automatic step(input logic t, input logic [7:0] l);
      @(negedge clk);
      trig = t;
      len  = l;
      @(posedge clk);
      model_edge(t, l);
      #1;
      check("out", out, e_out);
      check("done", done, e_done);
      check("ovr", ovr, e_ovr);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 8'($urandom_range(0, 255)));
   endtask

   // Asynchronous reset pulse placed mid-cycle, away from both clock edges.
   task automatic async_reset();
      #2;
      rst = 1'b1;
      #1;
      check("rst_out", out, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ovr", ovr, 1'b0);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      n_edge   = 0;
      model_reset();
      rst  = 1'b1;
      trig = 1'b0;
      len  = 8'd0;
      #12;
      check("reset_out", out, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_ovr", ovr, 1'b0);
      rst = 1'b0;

      // Basic pulse, len=5
      idle(3);
      step(1'b1, 8'd5);
      idle(8);

      // Zero length ignored
      step(1'b1, 8'd0);
      idle(3);

      // Overlapping trigger, len=4, second trigger two edges later
      step(1'b1, 8'd4);
      step(1'b0, 8'd4);
      step(1'b1, 8'd4);
      idle(7);

      // Trigger on the final active edge with len=0 (ovr in both builds)
      step(1'b1, 8'd2);
      step(1'b0, 8'd9);
      step(1'b1, 8'd0);
      idle(3);

      // Back-to-back: retrigger during the done cycle
      step(1'b1, 8'd3);
      idle(2);
      step(1'b0, 8'd3);
      step(1'b1, 8'd3);
      idle(5);

      // len changes while active must not disturb the pulse
      step(1'b1, 8'd6);
      for (int i = 0; i < 8; i++) step(1'b0, 8'($urandom_range(1, 255)));

      // Trigger held high continuously
      for (int i = 0; i < 10; i++) step(1'b1, 8'd3);
      idle(4);

      // Reset mid-pulse, then trigger on the first edge after release
      step(1'b1, 8'd200);
      idle(49);
      async_reset();
      step(1'b1, 8'd200);
      idle(205);

      // Maximum length
      step(1'b1, 8'd255);
      idle(258);

      // Random traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         logic       t;
         logic [7:0] l;
         t = ($urandom_range(0, 3) == 0);
         l = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
         step(t, l);
         if ($urandom_range(0, 199) == 0) async_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
